// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED command sequencer: init table,
// page addressing command bases and the FSM state encodings.
package oled_pkg;

    localparam int INIT_LEN = 25;

    localparam logic [0:INIT_LEN-1][7:0] INIT_TABLE = {
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    localparam logic [7:0] PAGE_CMD_BASE = 8'hB0;
    localparam logic [7:0] COL_LO_CMD    = 8'h00;
    localparam logic [7:0] COL_HI_CMD    = 8'h10;

    typedef enum logic [2:0] {
        RST_LOW  = 3'd0,
        RST_WAIT = 3'd1,
        INIT     = 3'd2,
        PAGE_CMD = 3'd3,
        FILL     = 3'd4,
        DONE     = 3'd5
    } oled_state_e;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } oled_hs_e;

    // Page addressing triple: select page, then column low/high nibble = 0.
    function automatic logic [7:0] page_cmd_byte(input logic [1:0] idx, input logic [7:0] page);
        case (idx)
            2'd0:    page_cmd_byte = PAGE_CMD_BASE + page;
            2'd1:    page_cmd_byte = COL_LO_CMD;
            default: page_cmd_byte = COL_HI_CMD;
        endcase
    endfunction

endpackage

// File: rtl/oled_init_rom.sv
// Combinational lookup of the panel power-up command table.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [4:0] idx_i,
    output logic [7:0] byte_o
);

    always_comb begin
        byte_o = 8'h00;
        for (int i = 0; i < INIT_LEN; i++) begin
            if (idx_i == 5'(i)) begin
                byte_o = INIT_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/oled_cmd_seq.sv
// OLED bring-up and screen-fill sequencer: reset pulse, init commands, then
// per-page addressing plus data fill, one byte per spi_master handshake.
module oled_cmd_seq
    import oled_pkg::*;
#(
    parameter int RST_CYCLES = 500,
    parameter int NUM_PAGES  = 8,
    parameter int PAGE_COLS  = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        refresh,
    input  logic [7:0]  fill_pattern,
    input  logic        busy,
    output logic        send_en,
    output logic        send_dc,
    output logic [7:0]  send_data,
    output logic        oled_rst,
    output logic        done,
    output oled_state_e dbg_state_o
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int CW = (PAGE_COLS > 1) ? $clog2(PAGE_COLS) : 1;

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(NUM_PAGES - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(PAGE_COLS - 1);
    localparam logic [4:0]    INIT_LAST = 5'(INIT_LEN - 1);

    oled_state_e     state_q;
    oled_hs_e        hs_q;
    logic [RW-1:0]   rst_cnt_q;
    logic [4:0]      init_idx_q;
    logic [1:0]      cmd_idx_q;
    logic [PW-1:0]   page_q;
    logic [CW-1:0]   col_q;
    logic [7:0]      pattern_q;
    logic            send_en_q;
    logic            send_dc_q;
    logic [7:0]      send_data_q;
    logic            oled_rst_q;
    logic            done_q;

    logic [7:0]      rom_byte;
    logic            tx_dc_d;
    logic [7:0]      tx_data_d;

    oled_init_rom u_init_rom (
        .idx_i  (init_idx_q),
        .byte_o (rom_byte)
    );

    // Byte that the current phase would issue next.
    always_comb begin
        tx_dc_d   = 1'b0;
        tx_data_d = 8'h00;
        case (state_q)
            INIT:     tx_data_d = rom_byte;
            PAGE_CMD: tx_data_d = page_cmd_byte(cmd_idx_q, 8'(page_q));
            FILL: begin
                tx_dc_d   = 1'b1;
                tx_data_d = pattern_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_LOW;
            hs_q        <= ISSUE;
            rst_cnt_q   <= '0;
            init_idx_q  <= '0;
            cmd_idx_q   <= '0;
            page_q      <= '0;
            col_q       <= '0;
            pattern_q   <= 8'h00;
            send_en_q   <= 1'b0;
            send_dc_q   <= 1'b0;
            send_data_q <= 8'h00;
            oled_rst_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            send_en_q <= 1'b0;
            case (state_q)
                RST_LOW: begin
                    if (rst_cnt_q == RST_LAST) begin
                        rst_cnt_q  <= '0;
                        oled_rst_q <= 1'b1;
                        state_q    <= RST_WAIT;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RW'(1);
                    end
                end
                RST_WAIT: begin
                    if (rst_cnt_q == RST_LAST) begin
                        rst_cnt_q <= '0;
                        hs_q      <= ISSUE;
                        state_q   <= INIT;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RW'(1);
                    end
                end
                INIT, PAGE_CMD, FILL: begin
                    case (hs_q)
                        ISSUE: begin
                            if (!busy) begin
                                send_en_q   <= 1'b1;
                                send_dc_q   <= tx_dc_d;
                                send_data_q <= tx_data_d;
                                hs_q        <= WAIT_HI;
                            end
                        end
                        WAIT_HI: begin
                            if (busy) begin
                                hs_q <= WAIT_LO;
                            end
                        end
                        WAIT_LO: begin
                            // Byte accepted: advance exactly one position.
                            if (!busy) begin
                                hs_q <= ISSUE;
                                if (state_q == INIT) begin
                                    if (init_idx_q == INIT_LAST) begin
                                        init_idx_q <= '0;
                                        pattern_q  <= fill_pattern;
                                        state_q    <= PAGE_CMD;
                                    end else begin
                                        init_idx_q <= init_idx_q + 5'd1;
                                    end
                                end else if (state_q == PAGE_CMD) begin
                                    if (cmd_idx_q == 2'd2) begin
                                        cmd_idx_q <= '0;
                                        state_q   <= FILL;
                                    end else begin
                                        cmd_idx_q <= cmd_idx_q + 2'd1;
                                    end
                                end else if (col_q == COL_LAST) begin
                                    col_q <= '0;
                                    if (page_q == PAGE_LAST) begin
                                        page_q  <= '0;
                                        done_q  <= 1'b1;
                                        state_q <= DONE;
                                    end else begin
                                        page_q  <= page_q + PW'(1);
                                        state_q <= PAGE_CMD;
                                    end
                                end else begin
                                    col_q <= col_q + CW'(1);
                                end
                            end
                        end
                        default: hs_q <= ISSUE;
                    endcase
                end
                DONE: begin
                    if (refresh) begin
                        pattern_q <= fill_pattern;
                        done_q    <= 1'b0;
                        page_q    <= '0;
                        cmd_idx_q <= '0;
                        col_q     <= '0;
                        hs_q      <= ISSUE;
                        state_q   <= PAGE_CMD;
                    end
                end
                default: state_q <= RST_LOW;
            endcase
        end
    end

    assign send_en     = send_en_q;
    assign send_dc     = send_dc_q;
    assign send_data   = send_data_q;
    assign oled_rst    = oled_rst_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_oled_cmd_seq.sv
// Bench for oled_cmd_seq: behavioural spi_master, expected-byte scoreboard,
// reset/refresh/stall scenarios and a final summary.
module tb_oled_cmd_seq;
  import oled_pkg::*;

  localparam int RST_CYC = 10;

  logic        clk;
  logic        rst_n;
  logic        refresh;
  logic [7:0]  fill_pattern;
  logic        busy;
  logic        send_en;
  logic        send_dc;
  logic [7:0]  send_data;
  logic        oled_rst;
  logic        done;
  oled_state_e dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8:0] exp_q[$];
  logic [7:0] init_bytes [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

  int   strobe_cnt = 0;
  int   byte_idx = 0;
  int   busy_viol = 0;
  int   hold_viol = 0;
  logic stall_req = 0;
  logic stall_seen = 0;

  oled_cmd_seq #(.RST_CYCLES(RST_CYC), .NUM_PAGES(8), .PAGE_COLS(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .refresh      (refresh),
    .fill_pattern (fill_pattern),
    .busy         (busy),
    .send_en      (send_en),
    .send_dc      (send_dc),
    .send_data    (send_data),
    .oled_rst     (oled_rst),
    .done         (done),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, init_bytes[i]});
  endtask

  task automatic push_pages(input logic [7:0] pat);
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back({1'b0, 8'hB0 + 8'(p)});
      exp_q.push_back(9'h000);
      exp_q.push_back(9'h010);
      for (int c = 0; c < 128; c++) exp_q.push_back({1'b1, pat});
    end
  endtask

  task automatic sb_pop(input logic [8:0] got);
    byte_idx++;
    if (exp_q.size() == 0) check($sformatf("sb_underflow_%0d", byte_idx), 0, 1);
    else check($sformatf("byte_%0d", byte_idx), 32'(got), 32'(exp_q.pop_front()));
  endtask

  // spi_master model: busy rises right after the strobe and holds 2..20 cycles
  initial begin
    int hold;
    busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (send_en && rst_n) begin
        sb_pop({send_dc, send_data});
        busy = 1'b1;
        hold = $urandom_range(2, 20);
        if (stall_req) begin
          hold += 200;
          stall_req = 1'b0;
          stall_seen = 1'b1;
        end
        while (hold > 0 && rst_n) begin
          @(posedge clk); #1;
          hold--;
        end
        busy = 1'b0;
      end
    end
  end

  // protocol monitor: strobe count, no strobe while a byte is in flight, held dc/data
  logic       pend = 1'b0;
  logic       busy_seen = 1'b0;
  logic       prev_en = 1'b0;
  logic [8:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      busy_seen = 1'b0;
    end else if (send_en) begin
      strobe_cnt++;
      if (pend || prev_en) busy_viol++;
      held = {send_dc, send_data};
      pend = 1'b1;
      busy_seen = busy;
    end else if (pend) begin
      if (busy) begin
        busy_seen = 1'b1;
        if ({send_dc, send_data} !== held) hold_viol++;
      end else if (busy_seen) begin
        pend = 1'b0;
      end
    end
    prev_en = send_en && rst_n;
  end

  task automatic pulse_refresh();
    @(posedge clk); #1;
    refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
  endtask

  task automatic wait_strobes(input string tag, input int base, input int n);
    int k;
    k = 0;
    while ((strobe_cnt - base) < n && k < 20000) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'((strobe_cnt - base) >= n), 1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 30000) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_send_en"}, 32'(send_en), 0);
    check({tag, "_send_dc"}, 32'(send_dc), 0);
    check({tag, "_send_data"}, 32'(send_data), 0);
    check({tag, "_oled_rst"}, 32'(oled_rst), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(RST_LOW));
  endtask

  // After rst_n rises: oled_rst low RST_CYC cycles, then >= RST_CYC cycles to first strobe.
  task automatic measure_reset(input string tag);
    int cnt;
    cnt = 0;
    while (!oled_rst && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_rst_low_cycles"}, 32'(cnt), RST_CYC);
    cnt = 0;
    while (!send_en && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_first_strobe_gap_ok"}, 32'(cnt >= RST_CYC && send_en), 1);
    check({tag, "_first_byte"}, 32'({send_dc, send_data}), 32'h0AE);
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    refresh = 1'b0;
    fill_pattern = 8'h00;
    #3;
    check_reset_outputs("por");

    // run 1: full bring-up, refresh during INIT ignored, long busy stall mid-fill
    push_init();
    push_pages(8'h00);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    base = strobe_cnt;
    measure_reset("rel1");
    wait_strobes("reach_init_byte3", base, 3);
    pulse_refresh();
    check("init_refresh_done", 32'(done), 0);
    wait_strobes("reach_fill", base, 300);
    stall_req = 1'b1;
    wait_done("run1_done");
    check("run1_strobes", 32'(strobe_cnt - base), 1073);
    check("run1_queue_empty", 32'(exp_q.size()), 0);
    check("run1_stall_applied", 32'(stall_seen), 1);
    base = strobe_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("done_idle_strobes", 32'(strobe_cnt - base), 0);
    check("done_idle_done", 32'(done), 1);

    // run 2: refresh with FF
    fill_pattern = 8'hFF;
    push_pages(8'hFF);
    base = strobe_cnt;
    pulse_refresh();
    check("run2_done_cleared", 32'(done), 0);
    wait_done("run2_done");
    check("run2_strobes", 32'(strobe_cnt - base), 1048);
    check("run2_queue_empty", 32'(exp_q.size()), 0);

    // run 3: pattern changes mid-fill must not leak into this fill
    fill_pattern = 8'h55;
    push_pages(8'h55);
    base = strobe_cnt;
    pulse_refresh();
    wait_strobes("run3_mid", base, 200);
    fill_pattern = 8'hAA;
    wait_done("run3_done");
    check("run3_strobes", 32'(strobe_cnt - base), 1048);
    check("run3_queue_empty", 32'(exp_q.size()), 0);

    // run 4: reset during page 3, full restart
    fill_pattern = 8'h11;
    push_pages(8'h11);
    base = strobe_cnt;
    pulse_refresh();
    wait_strobes("run4_page3", base, 450);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    fill_pattern = 8'h00;
    push_init();
    push_pages(8'h00);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    base = strobe_cnt;
    measure_reset("rel2");
    wait_done("run4_done");
    check("run4_strobes", 32'(strobe_cnt - base), 1073);
    check("run4_queue_empty", 32'(exp_q.size()), 0);

    check("strobe_while_busy", 32'(busy_viol), 0);
    check("dc_data_hold", 32'(hold_viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
